// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side byte buffer between the UART receiver and the CM configuration
// module. Received bytes are queued in order and the oldest byte is presented
// first-word-fall-through: RXD_Data is valid whenever Empty is low, and CM
// consumes it by pulsing Rd_En.
//
// Handshake semantics (both sides):
//   - Write side: RX_Valid is a one-cycle strobe with no back-pressure. The
//     byte is stored if the queue is not full, or if a pop is accepted in
//     the same cycle. Otherwise the byte is dropped and Overflow becomes
//     sticky-high.
//   - Read side: Empty acts as the inverse of "valid". A pop is accepted only
//     when Rd_En=1 and Empty=0. Rd_En while Empty has no effect.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   RX_Data      in   byte from UART receiver
//   RX_Valid     in   strobe: RX_Data holds a new byte this cycle
//   Rd_En        in   pop request from CM
//   Overflow_Clr in   clears the sticky Overflow flag
//   RXD_Data     out  head-of-queue byte, zero while Empty
//   Empty        out  queue holds no bytes
//   Full         out  queue holds FIFO_DEPTH bytes
//   Count        out  number of stored bytes, 0..FIFO_DEPTH
//   Overflow     out  sticky: a byte was dropped because the queue was full
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int UART_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int ADDR_WIDTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [UART_DATA_WIDTH-1:0] RX_Data,
    input  logic                       RX_Valid,
    input  logic                       Rd_En,
    input  logic                       Overflow_Clr,
    output logic [UART_DATA_WIDTH-1:0] RXD_Data,
    output logic                       Empty,
    output logic                       Full,
    output logic [ADDR_WIDTH:0]        Count,
    output logic                       Overflow
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    // Storage array. Not reset: contents are never visible while Empty.
    logic [UART_DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  overflow_q;

    logic rd_accept;
    logic wr_accept;
    logic drop_event;

    // Flags derive only from the registered count, so there is no path from
    // any input to Empty/Full.
    assign Empty = (count_q == '0);
    assign Full  = (count_q == DEPTH_CNT);

    // A pop in the same cycle frees a slot, so a full queue can still accept
    // a write. An empty queue cannot pop, so a simultaneous read is ignored.
    assign rd_accept  = Rd_En & ~Empty;
    assign wr_accept  = RX_Valid & (~Full | rd_accept);
    assign drop_event = RX_Valid & Full & ~rd_accept;

    // Byte storage.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= RX_Data;
        end
    end

    // Pointers wrap naturally at FIFO_DEPTH (power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (wr_accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (rd_accept) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Fill count: unchanged when a write and a read coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            case ({wr_accept, rd_accept})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow. A drop in the same cycle as a clear wins, so no event
    // is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (drop_event) begin
            overflow_q <= 1'b1;
        end else if (Overflow_Clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign Count    = count_q;
    assign Overflow = overflow_q;

    // FWFT head: a mux driven from registers only, forced to zero while
    // Empty so stale memory contents never leak out.
    assign RXD_Data = Empty ? '0 : mem[rd_ptr];

endmodule
